wb_rr_arbiter: RTL and testbench
================================

# wb_rr_arbiter

Round-robin Wishbone bus arbiter that shares one slave port between NUM_M Wishbone masters (instances of the team's `master` block or equivalents). It sits between the masters and the slave interconnect. It grants the bus per bus cycle (CYC-level lock), routes the owner's address, data and tag signals to the slave, and returns ACK only to the owner. A watchdog aborts any cycle whose slave never acknowledges.

## Interface
Parameters:
- NUM_M, 4: number of masters (2..8).
- ADR_W, 32: address width.
- DATA_W, 32: data width.
- SEL_W, 4: byte-select width.
- TAG_W, 4: width of each tag bus (TGA/TGD/TGC).
- TIMEOUT, 255: maximum number of cycles with STB high and no ACK before abort (1..65535).

Ports (masters' buses are flattened; master k occupies slice k):
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- m_cyc_i  in  NUM_M  per-master CYC.
- m_stb_i  in  NUM_M  per-master STB.
- m_we_i  in  NUM_M  per-master WE.
- m_adr_i  in  NUM_M*ADR_W  per-master address.
- m_sel_i  in  NUM_M*SEL_W  per-master byte select.
- m_dat_i  in  NUM_M*DATA_W  per-master write data.
- m_tga_i, m_tgd_i, m_tgc_i  in  NUM_M*TAG_W each  per-master tags.
- m_dat_o  out  DATA_W  read data broadcast to all masters (= s_dat_i).
- m_tgd_o  out  TAG_W  read tag broadcast (= s_tgd_i).
- m_ack_o  out  NUM_M  ACK, owner bit only.
- m_err_o  out  NUM_M  one-cycle timeout error, owner bit only.
- s_cyc_o, s_stb_o, s_we_o  out  1  to slave.
- s_adr_o  out  ADR_W  to slave.
- s_sel_o  out  SEL_W  to slave.
- s_dat_o  out  DATA_W  to slave.
- s_tga_o, s_tgd_o, s_tgc_o  out  TAG_W  to slave.
- s_dat_i  in  DATA_W  from slave.
- s_tgd_i  in  TAG_W  from slave.
- s_ack_i  in  1  from slave.
- gnt_o  out  NUM_M  registered one-hot grant; all zero when idle.

## Operation
States:
- IDLE: no owner.
- BUSY: owner holds the bus.
- ABORT: timeout hit; waiting for the owner to drop CYC.

Transitions:
- IDLE→BUSY at the edge where any m_cyc_i is high. The winner is the first requester found searching upward (with wrap) from last+1.
- BUSY→BUSY, new owner, at the edge where the owner's m_cyc_i is low and another master requests. Round-robin continues from the old owner+1. There is no dead cycle.
- BUSY→IDLE at the edge where the owner's m_cyc_i is low and no other master requests.
- BUSY→ABORT at the edge where the watchdog count reaches TIMEOUT.
- ABORT→IDLE at the edge where the owner's m_cyc_i is low.

Datapath:
- BUSY: s_* outputs are the combinational mux of the owner's m_* inputs. s_cyc_o/s_stb_o are additionally gated by the owner's m_cyc_i.
- BUSY: m_ack_o[owner] = s_ack_i & s_stb_o. All other m_ack_o bits are 0.
- IDLE and ABORT: s_cyc_o=s_stb_o=0, the remaining s_* outputs = 0, and m_ack_o = 0.

Watchdog:
- The 16-bit counter increments each BUSY cycle with s_stb_o=1 and s_ack_i=0.
- It clears on ACK, on a grant change, and outside BUSY.
- At the edge where the count reaches TIMEOUT, m_err_o[owner] pulses high for exactly one cycle (the first ABORT cycle).

"last" pointer:
- Updated to the owner index on every grant.
- Reset value NUM_M-1, so master 0 wins first.

Reset (rst_i=0), asynchronous: state=IDLE, gnt_o=0, counter=0, last=NUM_M-1. Consequently all s_cyc_o/s_stb_o/m_ack_o/m_err_o are 0 immediately, even mid-cycle.

## Timing
- Grant latency: m_cyc_i high before edge k → gnt_o valid and s_cyc_o high after edge k. One cycle minimum.
- ACK path is combinational, with zero added latency. A slave ACK in cycle n reaches the owner in cycle n. Classic single and block cycles are both supported.
- Owner release: with owner cyc_i low in cycle n, the new owner drives the slave from cycle n+1.
- Same-cycle s_ack_i and watchdog terminal count: ACK wins, the counter clears, and no error is raised.
- Requests from non-owners during BUSY are ignored until release, with no preemption.
- An owner holding CYC with STB low never times out.

## Test plan
- Reset/single master: assert rst_i=0 then 1, raise m_cyc_i[0]=m_stb_i[0]=1 with adr 0x100, slave ACKs 3 cycles later. Required: gnt_o=0001 one cycle after request, s_adr_o=0x100, m_ack_o=0001 in the ACK cycle only.
- Fairness: all four masters hold CYC continuously, each releasing after one ACK. Required: grant order 0,1,2,3,0, with no idle cycle between owners.
- Lock: master 2 owns and does a 4-beat block cycle while master 1 requests. Required: master 1 is not granted until master 2 drops CYC, and all 4 ACKs go to bit 2.
- Timeout: TIMEOUT=8, slave never ACKs. Required: m_err_o[owner] high for exactly one cycle 8 STB cycles after the start, s_cyc_o low from that cycle, state returns to IDLE after the owner drops CYC.
- ACK/terminal collision: slave ACK on exactly the TIMEOUT-th stalled cycle. Required: ACK delivered and no m_err_o.
- Reset mid-cycle: rst_i=0 while BUSY. Required: s_cyc_o, gnt_o, m_ack_o are 0 immediately, and after release master 0 has first priority.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter
// Round-robin Wishbone arbiter: shares one slave port between NUM_M masters.
// The bus is granted per bus cycle and held while the owner keeps CYC high.
// A watchdog aborts a cycle whose slave never acknowledges.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-low reset
//   m_*_i                 flattened per-master request buses (master k = slice k)
//   m_dat_o, m_tgd_o      read data / read tag broadcast to all masters
//   m_ack_o, m_err_o      per-master ACK and one-cycle timeout error (owner only)
//   s_*_o                 muxed owner request towards the slave
//   s_dat_i, s_tgd_i,
//   s_ack_i               slave response
//   gnt_o                 registered one-hot grant, zero when idle
module wb_rr_arbiter #(
  parameter int NUM_M   = 4,
  parameter int ADR_W   = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_M-1:0]        m_cyc_i,
  input  logic [NUM_M-1:0]        m_stb_i,
  input  logic [NUM_M-1:0]        m_we_i,
  input  logic [NUM_M*ADR_W-1:0]  m_adr_i,
  input  logic [NUM_M*SEL_W-1:0]  m_sel_i,
  input  logic [NUM_M*DATA_W-1:0] m_dat_i,
  input  logic [NUM_M*TAG_W-1:0]  m_tga_i,
  input  logic [NUM_M*TAG_W-1:0]  m_tgd_i,
  input  logic [NUM_M*TAG_W-1:0]  m_tgc_i,
  output logic [DATA_W-1:0]       m_dat_o,
  output logic [TAG_W-1:0]        m_tgd_o,
  output logic [NUM_M-1:0]        m_ack_o,
  output logic [NUM_M-1:0]        m_err_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADR_W-1:0]        s_adr_o,
  output logic [SEL_W-1:0]        s_sel_o,
  output logic [DATA_W-1:0]       s_dat_o,
  output logic [TAG_W-1:0]        s_tga_o,
  output logic [TAG_W-1:0]        s_tgd_o,
  output logic [TAG_W-1:0]        s_tgc_o,
  input  logic [DATA_W-1:0]       s_dat_i,
  input  logic [TAG_W-1:0]        s_tgd_i,
  input  logic                    s_ack_i,
  output logic [NUM_M-1:0]        gnt_o
);

  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [NUM_M-1:0] gnt_q, gnt_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic             busy;
  logic             own_cyc;
  logic             stall;

  // Round-robin search from last+1 upward with wrap. The loop walks from the
  // farthest candidate to the nearest so the nearest requester is written last.
  always_comb begin
    winner  = last_q;
    any_req = 1'b0;
    for (int i = NUM_M; i >= 1; i--) begin
      if (m_cyc_i[(int'(last_q) + i) % NUM_M]) begin
        winner  = IDX_W'((int'(last_q) + i) % NUM_M);
        any_req = 1'b1;
      end
    end
  end

  // Datapath: owner's request goes to the slave only while BUSY.
  assign busy    = (state_q == BUSY);
  assign own_cyc = m_cyc_i[owner_q];
  assign s_cyc_o = busy & own_cyc;
  assign s_stb_o = s_cyc_o & m_stb_i[owner_q];
  assign s_we_o  = busy & m_we_i[owner_q];
  assign s_adr_o = busy ? m_adr_i[int'(owner_q)*ADR_W  +: ADR_W]  : '0;
  assign s_sel_o = busy ? m_sel_i[int'(owner_q)*SEL_W  +: SEL_W]  : '0;
  assign s_dat_o = busy ? m_dat_i[int'(owner_q)*DATA_W +: DATA_W] : '0;
  assign s_tga_o = busy ? m_tga_i[int'(owner_q)*TAG_W  +: TAG_W]  : '0;
  assign s_tgd_o = busy ? m_tgd_i[int'(owner_q)*TAG_W  +: TAG_W]  : '0;
  assign s_tgc_o = busy ? m_tgc_i[int'(owner_q)*TAG_W  +: TAG_W]  : '0;

  assign m_dat_o = s_dat_i;
  assign m_tgd_o = s_tgd_i;
  // gnt_q is exactly the owner bit while BUSY; s_stb_o is already zero otherwise.
  assign m_ack_o = (s_stb_o & s_ack_i) ? gnt_q : '0;
  assign m_err_o = err_q ? gnt_q : '0;
  assign gnt_o   = gnt_q;

  assign stall = s_stb_o & ~s_ack_i;

  // Next-state logic. The counter defaults to zero, which covers every
  // clear condition (ACK, grant change, not BUSY) in one place.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; an unassigned path in combinational logic infers a latch.
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    cnt_d   = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BUSY;
          owner_d = winner;
          last_d  = winner;
          gnt_d   = NUM_M'(1) << winner;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          // Owner released: hand over in the same edge (no dead cycle).
          if (any_req) begin
            owner_d = winner;
            last_d  = winner;
            gnt_d   = NUM_M'(1) << winner;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (stall) begin
          if (int'(cnt_q) + 1 == TIMEOUT) begin
            state_d = ABORT;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else if (!s_ack_i) begin
          // STB low with CYC held: count frozen, never times out.
          cnt_d = cnt_q;
        end
      end
      ABORT: begin
        if (!own_cyc) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_M - 1);
      gnt_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter
// Directed bench for wb_rr_arbiter (NUM_M=4, TIMEOUT=8). Inputs are driven
// at the falling edge, outputs are sampled 1 ns later.
module tb_wb_rr_arbiter;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TW = 4;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic [NM-1:0]   m_cyc_i = '0, m_stb_i = '0, m_we_i = '0;
  logic [NM*AW-1:0] m_adr_i;
  logic [NM*SW-1:0] m_sel_i;
  logic [NM*DW-1:0] m_dat_i;
  logic [NM*TW-1:0] m_tga_i, m_tgd_i, m_tgc_i;
  logic [DW-1:0]   m_dat_o;
  logic [TW-1:0]   m_tgd_o;
  logic [NM-1:0]   m_ack_o, m_err_o, gnt_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [SW-1:0]   s_sel_o;
  logic [DW-1:0]   s_dat_o;
  logic [TW-1:0]   s_tga_o, s_tgd_o, s_tgc_o;
  logic [DW-1:0]   s_dat_i = '0;
  logic [TW-1:0]   s_tgd_i = '0;
  logic            s_ack_i = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  wb_rr_arbiter #(
    .NUM_M(NM), .ADR_W(AW), .DATA_W(DW), .SEL_W(SW), .TAG_W(TW), .TIMEOUT(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_dat_i(m_dat_i),
    .m_tga_i(m_tga_i), .m_tgd_i(m_tgd_i), .m_tgc_i(m_tgc_i),
    .m_dat_o(m_dat_o), .m_tgd_o(m_tgd_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
    .s_tga_o(s_tga_o), .s_tgd_o(s_tgd_o), .s_tgc_o(s_tgc_o),
    .s_dat_i(s_dat_i), .s_tgd_i(s_tgd_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o)
  );

  task automatic set_req(input int k, input logic on);
    m_cyc_i[k] = on;
    m_stb_i[k] = on;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i   = 1'b0;
    m_cyc_i = '0;
    m_stb_i = '0;
    s_ack_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    m_cyc_i = '1;
    m_stb_i = '1;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    total++; if (gnt_o !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt_o); end
    total++; if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL reset_cyc: got %b want 0", s_cyc_o); end
    total++; if (m_err_o !== 4'b0000) begin bad++; $display("FAIL reset_err: got %b want 0000", m_err_o); end
    m_cyc_i = '0;
    m_stb_i = '0;
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk_i);
    set_req(0, 1'b1);
    #1;
    total++; if (gnt_o !== 4'b0000) begin bad++; $display("FAIL single_early_gnt: got %b want 0000", gnt_o); end
    @(negedge clk_i); #1;
    total++; if (gnt_o !== 4'b0001) begin bad++; $display("FAIL single_gnt: got %b want 0001", gnt_o); end
    total++; if (s_cyc_o !== 1'b1) begin bad++; $display("FAIL single_cyc: got %b want 1", s_cyc_o); end
    total++; if (s_adr_o !== 32'h100) begin bad++; $display("FAIL single_adr: got %h want 00000100", s_adr_o); end
    total++; if (s_tga_o !== 4'h1) begin bad++; $display("FAIL single_tga: got %h want 1", s_tga_o); end
    total++; if (m_ack_o !== 4'b0000) begin bad++; $display("FAIL single_noack: got %b want 0000", m_ack_o); end
    @(negedge clk_i);
    @(negedge clk_i);
    s_ack_i = 1'b1;
    s_dat_i = 32'hCAFE_F00D;
    #1;
    total++; if (m_ack_o !== 4'b0001) begin bad++; $display("FAIL single_ack: got %b want 0001", m_ack_o); end
    total++; if (m_dat_o !== 32'hCAFE_F00D) begin bad++; $display("FAIL single_rdata: got %h want cafef00d", m_dat_o); end
    @(negedge clk_i);
    s_ack_i = 1'b0;
    set_req(0, 1'b0);
    #1;
    total++; if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL single_release_cyc: got %b want 0", s_cyc_o); end
    @(negedge clk_i); #1;
    total++; if (gnt_o !== 4'b0000) begin bad++; $display("FAIL single_idle_gnt: got %b want 0000", gnt_o); end
  endtask

  task automatic test_fairness();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int prev;
    do_reset();
    m_cyc_i = '1;
    m_stb_i = '1;
    prev = -1;
    foreach (exp_order[i]) begin
      @(negedge clk_i);
      if (prev >= 0) set_req(prev, 1'b1);
      s_ack_i = 1'b1;
      #1;
      total++; if (gnt_o !== (4'b0001 << exp_order[i])) begin bad++; $display("FAIL fair_gnt[%0d]: got %b want owner %0d", i, gnt_o, exp_order[i]); end
      total++; if (m_ack_o !== (4'b0001 << exp_order[i])) begin bad++; $display("FAIL fair_ack[%0d]: got %b want owner %0d", i, m_ack_o, exp_order[i]); end
      @(negedge clk_i);
      s_ack_i = 1'b0;
      set_req(exp_order[i], 1'b0);
      prev = exp_order[i];
      #1;
      total++; if (gnt_o !== (4'b0001 << exp_order[i])) begin bad++; $display("FAIL fair_hold[%0d]: got %b want owner %0d", i, gnt_o, exp_order[i]); end
    end
    m_cyc_i = '0;
    m_stb_i = '0;
    @(negedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_lock();
    int acks2 = 0;
    int errs  = 0;
    do_reset();
    @(negedge clk_i);
    m_cyc_i[2] = 1'b1;
    m_we_i[2]  = 1'b1;
    @(negedge clk_i);
    m_cyc_i[1] = 1'b1;
    m_stb_i[1] = 1'b1;
    #1;
    total++; if (gnt_o !== 4'b0100) begin bad++; $display("FAIL lock_gnt: got %b want 0100", gnt_o); end
    // Owner holds CYC with STB low well past TIMEOUT: no error expected.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i); #1;
      if (m_err_o !== 4'b0000) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL lock_idle_err: got %0d err cycles want 0", errs); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      m_stb_i[2] = 1'b1;
      s_ack_i    = 1'b1;
      #1;
      if (m_ack_o === 4'b0100) acks2++;
    end
    total++; if (acks2 !== 4) begin bad++; $display("FAIL lock_acks: got %0d acks to bit2 want 4", acks2); end
    total++; if (s_we_o !== 1'b1 || s_dat_o !== 32'hD000_0002) begin bad++; $display("FAIL lock_wdata: got we=%b dat=%h want we=1 dat=d0000002", s_we_o, s_dat_o); end
    @(negedge clk_i);
    s_ack_i = 1'b0;
    set_req(2, 1'b0);
    m_we_i[2] = 1'b0;
    #1;
    total++; if (gnt_o !== 4'b0100) begin bad++; $display("FAIL lock_no_preempt: got %b want 0100", gnt_o); end
    @(negedge clk_i); #1;
    total++; if (gnt_o !== 4'b0010) begin bad++; $display("FAIL lock_handover: got %b want 0010", gnt_o); end
    total++; if (s_adr_o !== 32'h110) begin bad++; $display("FAIL lock_adr1: got %h want 00000110", s_adr_o); end
    set_req(1, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_timeout();
    int early = 0;
    do_reset();
    @(negedge clk_i);
    set_req(3, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_i); #1;
      if (m_err_o !== 4'b0000 || s_stb_o !== 1'b1) early++;
    end
    total++; if (early !== 0) begin bad++; $display("FAIL to_early: got %0d bad stall cycles want 0", early); end
    @(negedge clk_i); #1;
    total++; if (m_err_o !== 4'b1000) begin bad++; $display("FAIL to_err: got %b want 1000", m_err_o); end
    total++; if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL to_cyc: got %b want 0", s_cyc_o); end
    @(negedge clk_i); #1;
    total++; if (m_err_o !== 4'b0000) begin bad++; $display("FAIL to_err_pulse: got %b want 0000", m_err_o); end
    total++; if (gnt_o !== 4'b1000) begin bad++; $display("FAIL to_abort_gnt: got %b want 1000", gnt_o); end
    set_req(3, 1'b0);
    @(negedge clk_i); #1;
    total++; if (gnt_o !== 4'b0000) begin bad++; $display("FAIL to_idle: got %b want 0000", gnt_o); end
    set_req(0, 1'b1);
    @(negedge clk_i); #1;
    total++; if (gnt_o !== 4'b0001) begin bad++; $display("FAIL to_regrant: got %b want 0001", gnt_o); end
    set_req(0, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_collision();
    do_reset();
    @(negedge clk_i);
    set_req(1, 1'b1);
    for (int i = 1; i <= 7; i++) @(negedge clk_i);
    @(negedge clk_i);
    s_ack_i = 1'b1;
    #1;
    total++; if (m_ack_o !== 4'b0010) begin bad++; $display("FAIL coll_ack: got %b want 0010", m_ack_o); end
    @(negedge clk_i);
    s_ack_i = 1'b0;
    #1;
    total++; if (m_err_o !== 4'b0000 || s_cyc_o !== 1'b1) begin bad++; $display("FAIL coll_noerr: got err=%b cyc=%b want err=0000 cyc=1", m_err_o, s_cyc_o); end
    @(negedge clk_i); #1;
    total++; if (m_err_o !== 4'b0000) begin bad++; $display("FAIL coll_noerr2: got %b want 0000", m_err_o); end
    set_req(1, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk_i);
    set_req(2, 1'b1);
    @(negedge clk_i);
    s_ack_i = 1'b1;
    #2;
    rst_i = 1'b0;
    #1;
    total++; if (s_cyc_o !== 1'b0 || gnt_o !== 4'b0000 || m_ack_o !== 4'b0000) begin bad++; $display("FAIL rstmid_async: got cyc=%b gnt=%b ack=%b want 0/0000/0000", s_cyc_o, gnt_o, m_ack_o); end
    @(negedge clk_i);
    rst_i   = 1'b1;
    s_ack_i = 1'b0;
    m_cyc_i = '1;
    m_stb_i = '1;
    @(negedge clk_i); #1;
    total++; if (gnt_o !== 4'b0001) begin bad++; $display("FAIL rstmid_prio: got %b want 0001", gnt_o); end
    m_cyc_i = '0;
    m_stb_i = '0;
    @(negedge clk_i);
  endtask

  initial begin
    for (int k = 0; k < NM; k++) begin
      m_adr_i[k*AW +: AW] = 32'h100 + 32'(k) * 32'h10;
      m_dat_i[k*DW +: DW] = 32'hD000_0000 + 32'(k);
      m_sel_i[k*SW +: SW] = 4'hF;
      m_tga_i[k*TW +: TW] = 4'(k + 1);
      m_tgd_i[k*TW +: TW] = 4'(k + 5);
      m_tgc_i[k*TW +: TW] = 4'(k + 9);
    end
    test_reset();
    test_single();
    test_fairness();
    test_lock();
    test_timeout();
    test_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
